parking_meter_ctrl: RTL

Controller that owns the parking meter's remaining-time register and sequences it from coin and preset events. It consumes single-cycle button pulses and a 2 Hz tick from the clock-divider stage, counts time down once per second, saturates at the display limit, and drives the flash control that the seven-segment display stage applies. It sits between the debounced input stage and the BCD/display path.

---
 rtl/parking_meter_pkg.sv | 37 +++
 rtl/parking_meter_ctrl_blink.sv | 51 +++++
 rtl/parking_meter_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/parking_meter_pkg.sv
// Shared constants and state encoding for the parking meter controller.
package parking_meter_pkg;

    localparam int unsigned TW         = 14;
    localparam int unsigned MAX_TIME   = 9999;
    localparam int unsigned LOW_THRESH = 180;

    localparam int unsigned ADD0 = 60;
    localparam int unsigned ADD1 = 120;
    localparam int unsigned ADD2 = 180;
    localparam int unsigned ADD3 = 300;

    localparam int unsigned PRESET0 = 16;
    localparam int unsigned PRESET1 = 150;

    typedef logic [TW-1:0] time_t;
    // One spare bit so decrement/add results can exceed MAX_TIME before clamping.
    typedef logic [TW:0]   wide_t;

    typedef enum logic [1:0] {
        StExpired = 2'd0,
        StLow     = 2'd1,
        StNormal  = 2'd2
    } meter_state_e;

    // Display state implied by a remaining-time value.
    function automatic meter_state_e decode_state(input time_t t);
        if (t == '0) begin
            return StExpired;
        end else if (t < time_t'(LOW_THRESH)) begin
            return StLow;
        end else begin
            return StNormal;
        end
    endfunction

endpackage

// File: rtl/parking_meter_ctrl_blink.sv
// Half-second / second phase tracking and display flash control.
module meter_blink_gen
    import parking_meter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_2hz,
    input  logic         clear,
    input  meter_state_e state,
    output logic         second_elapsed,
    output logic         blank
);

    logic half_q, half_d;
    logic sec_phase_q, sec_phase_d;
    logic blank_q, blank_d;

    // Advance the flash phases; blank follows the state the meter is entering.
    always_comb begin
        second_elapsed = tick_2hz & half_q;
        half_d         = half_q ^ tick_2hz;
        sec_phase_d    = sec_phase_q ^ second_elapsed;
        if (clear) begin
            // Restart the blink with the display on.
            half_d      = 1'b0;
            sec_phase_d = 1'b0;
        end
        blank_d = 1'b0;
        unique case (state)
            StLow:     blank_d = half_d;
            StExpired: blank_d = sec_phase_d;
            default:   blank_d = 1'b0;
        endcase
    end

    // Phase and blank registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q      <= 1'b0;
            sec_phase_q <= 1'b0;
            blank_q     <= 1'b0;
        end else begin
            half_q      <= half_d;
            sec_phase_q <= sec_phase_d;
            blank_q     <= blank_d;
        end
    end

    assign blank = blank_q;

endmodule

// File: rtl/parking_meter_ctrl.sv
// Parking meter controller: remaining-time register, saturating add, state decode.
module parking_meter_ctrl
    import parking_meter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_2hz,
    input  logic [3:0]    add_pulse,
    input  logic [1:0]    preset_pulse,
    output logic [TW-1:0] time_left,
    output logic [1:0]    state,
    output logic          blank,
    output logic          expired
);

    time_t        time_q, time_d;
    meter_state_e state_q, state_d;
    logic         expired_q, expired_d;
    logic         second_elapsed;
    logic         clear;
    wide_t        sum;

    // Next remaining time: preset overrides everything, else decrement then add and clamp.
    always_comb begin
        clear = (preset_pulse != 2'b00) || (add_pulse != 4'b0000);
        sum   = {1'b0, time_q};
        if (second_elapsed && (time_q != '0)) begin
            sum = sum - wide_t'(1);
        end
        if (add_pulse[0]) sum = sum + wide_t'(ADD0);
        if (add_pulse[1]) sum = sum + wide_t'(ADD1);
        if (add_pulse[2]) sum = sum + wide_t'(ADD2);
        if (add_pulse[3]) sum = sum + wide_t'(ADD3);
        if (sum > wide_t'(MAX_TIME)) begin
            sum = wide_t'(MAX_TIME);
        end

        if (preset_pulse[0]) begin
            time_d = time_t'(PRESET0);
        end else if (preset_pulse[1]) begin
            time_d = time_t'(PRESET1);
        end else begin
            time_d = sum[TW-1:0];
        end

        state_d   = decode_state(time_d);
        expired_d = (time_d == '0);
    end

    // Time, state and expired registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q    <= '0;
            state_q   <= StExpired;
            expired_q <= 1'b1;
        end else begin
            time_q    <= time_d;
            state_q   <= state_d;
            expired_q <= expired_d;
        end
    end

    meter_blink_gen u_blink (
        .clk            (clk),
        .rst            (rst),
        .tick_2hz       (tick_2hz),
        .clear          (clear),
        .state          (state_d),
        .second_elapsed (second_elapsed),
        .blank          (blank)
    );

    assign time_left = time_q;
    assign state     = state_q;
    assign expired   = expired_q;

endmodule
